mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu.sv | 130 +++++++++++++
 tb/tb_mdu.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the MDU: operation codes beside the ALU codes, latency defaults, state and payload types.
package mdu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned OP_W             = 4;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    // ALU operation codes
    localparam logic [OP_W-1:0] ALUAdd  = 4'd0;
    localparam logic [OP_W-1:0] ALUSub  = 4'd1;
    localparam logic [OP_W-1:0] ALUAnd  = 4'd2;
    localparam logic [OP_W-1:0] ALUOr   = 4'd3;
    localparam logic [OP_W-1:0] ALUXor  = 4'd4;
    localparam logic [OP_W-1:0] ALUNor  = 4'd5;
    localparam logic [OP_W-1:0] ALUSlt  = 4'd6;
    localparam logic [OP_W-1:0] ALUSltu = 4'd7;

    // MDU operation codes; every code not listed is a no-op
    localparam logic [OP_W-1:0] MDUNone  = 4'd0;
    localparam logic [OP_W-1:0] MDUMult  = 4'd1;
    localparam logic [OP_W-1:0] MDUMultu = 4'd2;
    localparam logic [OP_W-1:0] MDUDiv   = 4'd3;
    localparam logic [OP_W-1:0] MDUDivu  = 4'd4;
    localparam logic [OP_W-1:0] MDUMthi  = 4'd5;
    localparam logic [OP_W-1:0] MDUMtlo  = 4'd6;
    localparam logic [OP_W-1:0] MDUMfhi  = 4'd7;
    localparam logic [OP_W-1:0] MDUMflo  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: results are computed at acceptance, parked in shadow registers,
// and committed to HI/LO when the latency counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [OP_W-1:0] MDUOp,
    input  logic            Start,
    output logic            Busy,
    output logic [XLEN-1:0] MDUOut
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hilo_t            hilo_q, hilo_d;
    hilo_t            shadow_q, shadow_d;
    logic             skip_q, skip_d;

    logic [2*XLEN-1:0] prod_s, prod_u;
    logic [XLEN-1:0]   divisor_g, quot_u, rem_u;
    logic [XLEN-1:0]   a_mag, b_mag, b_mag_g, q_mag, r_mag, quot_s, rem_s;
    logic              div_zero;

    // Sign-extended operands give the signed product in the low 64 bits
    assign prod_u = {{XLEN{1'b0}}, SrcA} * {{XLEN{1'b0}}, SrcB};
    assign prod_s = {{XLEN{SrcA[XLEN-1]}}, SrcA} * {{XLEN{SrcB[XLEN-1]}}, SrcB};

    assign div_zero  = (SrcB == '0);
    assign divisor_g = div_zero ? XLEN'(1) : SrcB;
    assign quot_u    = SrcA / divisor_g;
    assign rem_u     = SrcA % divisor_g;

    // Signed divide on magnitudes: quotient truncates toward zero, remainder follows the dividend
    assign a_mag   = SrcA[XLEN-1] ? (~SrcA + XLEN'(1)) : SrcA;
    assign b_mag   = SrcB[XLEN-1] ? (~SrcB + XLEN'(1)) : SrcB;
    assign b_mag_g = div_zero ? XLEN'(1) : b_mag;
    assign q_mag   = a_mag / b_mag_g;
    assign r_mag   = a_mag % b_mag_g;
    assign quot_s  = (SrcA[XLEN-1] ^ SrcB[XLEN-1]) ? (~q_mag + XLEN'(1)) : q_mag;
    assign rem_s   = SrcA[XLEN-1] ? (~r_mag + XLEN'(1)) : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hilo_q   <= '0;
            shadow_q <= '0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hilo_q   <= hilo_d;
            shadow_q <= shadow_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hilo_d   = hilo_q;
        shadow_d = shadow_q;
        skip_d   = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        MDUMult: begin
                            shadow_d = hilo_t'(prod_s);
                            skip_d   = 1'b0;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDUMultu: begin
                            shadow_d = hilo_t'(prod_u);
                            skip_d   = 1'b0;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDUDiv: begin
                            shadow_d = '{hi: rem_s, lo: quot_s};
                            skip_d   = div_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDUDivu: begin
                            shadow_d = '{hi: rem_u, lo: quot_u};
                            skip_d   = div_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDUMthi: hilo_d.hi = SrcA;
                        MDUMtlo: hilo_d.lo = SrcA;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // Start is ignored here, including on the committing edge
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!skip_q) begin
                        hilo_d = shadow_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy = (state_q == ST_BUSY);

    // Read port always shows committed HI/LO
    always_comb begin
        MDUOut = '0;
        case (MDUOp)
            MDUMfhi: MDUOut = hilo_q.hi;
            MDUMflo: MDUOut = hilo_q.lo;
            default: MDUOut = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUOut;

    int checks;
    int failures;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .MDUOut (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input logic [3:0] op);
        if (op == MDUMult || op == MDUMultu) return 5;
        if (op == MDUDiv || op == MDUDivu) return 10;
        return 0;
    endfunction

    // Architectural effect of an op on HI/LO once it has completed
    function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            MDUMult: begin
                p = sa * sb;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MDUMultu: begin
                up = ua * ub;
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            MDUDiv: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                hi_m = r[31:0];
                lo_m = q[31:0];
            end
            MDUDivu: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                hi_m = ur[31:0];
                lo_m = uq[31:0];
            end
            MDUMthi: hi_m = a;
            MDUMtlo: lo_m = a;
            default: ;
        endcase
    endfunction

    task automatic read_reg(input logic [3:0] op, output logic [31:0] v);
        logic [3:0] saved;
        saved = MDUOp;
        MDUOp = op;
        #1;
        v = MDUOut;
        MDUOp = saved;
    endtask

    // Present one Start for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = MDUNone;
    endtask

    // Count cycles that Busy remains high, bounded
    task automatic drain(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        Start = 1'b0;
        MDUOp = MDUNone;
        SrcA  = '0;
        SrcB  = '0;
        hi_m  = '0;
        lo_m  = '0;
        #3;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", v); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", v); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [31:0] v;
        int n;
        issue(MDUMthi, 32'hCAFE0001, 32'h0);
        model_apply(MDUMthi, 32'hCAFE0001, 32'h0);
        issue(MDUMult, 32'hFFFFFFFE, 32'd3);
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'hCAFE0001) begin failures++; $display("FAIL mult_old_hi got=%h exp=cafe0001", v); end
        drain(n);
        checks++;
        if (n != 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", v); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", v); end
        hi_m = 32'hFFFFFFFF;
        lo_m = 32'hFFFFFFFA;
    endtask

    task automatic test_multu();
        logic [31:0] v;
        int n;
        issue(MDUMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drain(n);
        checks++;
        if (n != 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", v); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", v); end
        hi_m = 32'hFFFFFFFE;
        lo_m = 32'h00000001;
    endtask

    task automatic test_div();
        logic [31:0] v;
        int n;
        issue(MDUDiv, 32'hFFFFFFF9, 32'd2);
        drain(n);
        checks++;
        if (n != 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", v); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", v); end
        // most-negative / -1 wraps to itself with zero remainder
        issue(MDUDiv, 32'h80000000, 32'hFFFFFFFF);
        drain(n);
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", v); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", v); end
        hi_m = 32'h0;
        lo_m = 32'h80000000;
    endtask

    task automatic test_div_zero();
        logic [31:0] v;
        int n;
        issue(MDUMthi, 32'h12345678, 32'h0);
        issue(MDUMtlo, 32'h0BADF00D, 32'h0);
        issue(MDUDiv, 32'd100, 32'd0);
        drain(n);
        checks++;
        if (n != 10) begin failures++; $display("FAIL div0_busy got=%0d exp=10", n); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'h12345678) begin failures++; $display("FAIL div0_hi got=%h exp=12345678", v); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h0BADF00D) begin failures++; $display("FAIL div0_lo got=%h exp=0badf00d", v); end
        issue(MDUDivu, 32'd100, 32'd0);
        drain(n);
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h0BADF00D) begin failures++; $display("FAIL divu0_lo got=%h exp=0badf00d", v); end
        hi_m = 32'h12345678;
        lo_m = 32'h0BADF00D;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int n;
        @(negedge clk);
        MDUOp = MDUMult; SrcA = 32'd7; SrcB = 32'd6; Start = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_on got=%0b exp=1", Busy); end
        MDUOp = MDUMtlo; SrcA = 32'h0000000A;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDUNone;
        repeat (3) @(negedge clk);
        // this negedge precedes the committing edge
        MDUOp = MDUMultu; SrcA = 32'd3; SrcB = 32'd4; Start = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_commit_start got=%0b exp=0", Busy); end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_next_accept got=%0b exp=1", Busy); end
        Start = 1'b0; MDUOp = MDUNone;
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'd42) begin failures++; $display("FAIL b2b_lo_kept got=%h exp=0000002a", v); end
        drain(n);
        checks++;
        if (n != 5) begin failures++; $display("FAIL b2b_busy2 got=%0d exp=5", n); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'd12) begin failures++; $display("FAIL b2b_lo2 got=%h exp=0000000c", v); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL b2b_hi2 got=%h exp=0", v); end
        hi_m = 32'd0;
        lo_m = 32'd12;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int n;
        issue(MDUDiv, 32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", Busy); end
        read_reg(MDUMfhi, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=0", v); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=0", v); end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'h0 || Busy !== 1'b0) begin
            failures++; $display("FAIL rst_no_commit lo=%h busy=%0b exp lo=0 busy=0", v, Busy);
        end
        hi_m = '0;
        lo_m = '0;
        issue(MDUMultu, 32'd9, 32'd11);
        drain(n);
        checks++;
        if (n != 5) begin failures++; $display("FAIL rst_first_busy got=%0d exp=5", n); end
        read_reg(MDUMflo, v);
        checks++;
        if (v !== 32'd99) begin failures++; $display("FAIL rst_first_lo got=%h exp=00000063", v); end
        lo_m = 32'd99;
    endtask

    task automatic test_random();
        logic [31:0] v, a, b;
        logic [3:0]  op;
        int n;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h80000000;
                default: ;
            endcase
            issue(op, a, b);
            drain(n);
            checks++;
            if (n != lat_of(op)) begin failures++; $display("FAIL rand_busy op=%0d got=%0d exp=%0d", op, n, lat_of(op)); end
            model_apply(op, a, b);
            read_reg(MDUMfhi, v);
            checks++;
            if (v !== hi_m) begin failures++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, v, hi_m); end
            read_reg(MDUMflo, v);
            checks++;
            if (v !== lo_m) begin failures++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, v, lo_m); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
